// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit path.
//   UART_DIV_W       - baud divider width used by uart_tx, uart_rx and uart_tx_sched
//   tx_sched_state_t - uart_tx_sched FSM state encoding
package uart_pkg;

  localparam int unsigned UART_DIV_W = 4;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    LAUNCH     = 3'd1,
    WAIT_START = 3'd2,
    WAIT_END   = 3'd3,
    GUARD      = 3'd4
  } tx_sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational rotate-priority pick among NUM_REQ requesters.
//   req     in  - request vector, one bit per requester
//   ptr     in  - index where the priority search starts
//   gnt     out - one-hot winner (all zero when nothing is requested)
//   gnt_idx out - binary index of the winner
//   any     out - at least one request is set
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               any
);

  logic [IDX_W-1:0] w_pos;

  // Walk the requesters starting at ptr; the first set bit wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    w_pos   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_pos = IDX_W'((32'(ptr) + k) % NUM_REQ);
      if (!any && req[w_pos]) begin
        any     = 1'b1;
        gnt_idx = w_pos;
      end
    end
    gnt[gnt_idx] = any;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one uart_tx between NUM_REQ requesters.
// Arbitrates round-robin in IDLE, latches the winner's byte and divider,
// fires a one-cycle Tx_Drive, follows Tx_Active through the frame and
// reports done or watchdog err back to the winner.
//   clk, rst   - clock, asynchronous active-low reset
//   req        - level requests; req_data / req_div hold per-requester slices
//   grant      - one-hot pulse when a request is accepted
//   done / err - one-hot pulse on frame completion / watchdog abort
//   busy       - high whenever the FSM is outside IDLE
//   Tx_Drive   - start pulse to uart_tx; tx_data / clk_div latched for it
//   Tx_Active  - busy flag fed back from uart_tx
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned DIV_W          = UART_DIV_W,
  parameter int unsigned TIMEOUT_W      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ*DIV_W-1:0]  req_div,
  output logic [NUM_REQ-1:0]        grant,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      busy,
  output logic                      Tx_Drive,
  output logic [DATA_W-1:0]         tx_data,
  output logic [DIV_W-1:0]          clk_div,
  input  logic                      Tx_Active
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_REQ - 1);

  tx_sched_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [TIMEOUT_W-1:0]  r_wd, w_wd_nxt;
  logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]    r_done, w_done_nxt;
  logic [NUM_REQ-1:0]    r_err, w_err_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_drive, w_drive_nxt;
  logic [DATA_W-1:0]     r_tx_data, w_tx_data_nxt;
  logic [DIV_W-1:0]      r_clk_div, w_clk_div_nxt;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDX_W-1:0]      w_gnt_idx;
  logic                  w_any;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (req),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx),
    .any     (w_any)
  );

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_idx_nxt     = r_idx;
    w_wd_nxt      = r_wd;
    w_grant_nxt   = '0;
    w_done_nxt    = '0;
    w_err_nxt     = '0;
    w_drive_nxt   = 1'b0;
    w_tx_data_nxt = r_tx_data;
    w_clk_div_nxt = r_clk_div;

    case (r_state)
      IDLE: begin
        // A transmitter still busy from elsewhere blocks arbitration.
        if (w_any && !Tx_Active) begin
          w_state_nxt = LAUNCH;
          w_grant_nxt = w_gnt;
          w_drive_nxt = 1'b1;
          w_idx_nxt   = w_gnt_idx;
          w_ptr_nxt   = (w_gnt_idx == IDX_LAST) ? '0 : w_gnt_idx + 1'b1;
          for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_gnt[i]) begin
              w_tx_data_nxt = req_data[i*DATA_W +: DATA_W];
              w_clk_div_nxt = req_div[i*DIV_W +: DIV_W];
            end
          end
        end
      end

      LAUNCH: begin
        w_state_nxt = WAIT_START;
        w_wd_nxt    = '0;
      end

      WAIT_START: begin
        if (Tx_Active) begin
          w_state_nxt = WAIT_END;
          w_wd_nxt    = '0;
        end else if (r_wd == WD_LAST) begin
          w_state_nxt      = GUARD;
          w_err_nxt[r_idx] = 1'b1;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end

      WAIT_END: begin
        if (!Tx_Active) begin
          w_state_nxt       = GUARD;
          w_done_nxt[r_idx] = 1'b1;
        end else if (r_wd == WD_LAST) begin
          w_state_nxt      = GUARD;
          w_err_nxt[r_idx] = 1'b1;
        end else begin
          w_wd_nxt = r_wd + 1'b1;
        end
      end

      GUARD: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_idx     <= '0;
      r_wd      <= '0;
      r_grant   <= '0;
      r_done    <= '0;
      r_err     <= '0;
      r_busy    <= 1'b0;
      r_drive   <= 1'b0;
      r_tx_data <= '0;
      r_clk_div <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_idx     <= w_idx_nxt;
      r_wd      <= w_wd_nxt;
      r_grant   <= w_grant_nxt;
      r_done    <= w_done_nxt;
      r_err     <= w_err_nxt;
      r_busy    <= w_busy_nxt;
      r_drive   <= w_drive_nxt;
      r_tx_data <= w_tx_data_nxt;
      r_clk_div <= w_clk_div_nxt;
    end
  end

  assign grant    = r_grant;
  assign done     = r_done;
  assign err      = r_err;
  assign busy     = r_busy;
  assign Tx_Drive = r_drive;
  assign tx_data  = r_tx_data;
  assign clk_div  = r_clk_div;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched: directed bench for uart_tx_sched with a scoreboard of
// expected frames and a small uart_tx stand-in driving Tx_Active.
module tb_uart_tx_sched;

  localparam int WD_CYC  = 16;
  localparam int M_NORM  = 0;
  localparam int M_LOW   = 1;
  localparam int M_FORCE = 2;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic [3:0] div;
    bit         is_err;
    int         gap;
    int         at_cyc;
    int         gcyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [15:0] req_div;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic [3:0]  err;
  logic        busy;
  logic        Tx_Drive;
  logic [7:0]  tx_data;
  logic [3:0]  clk_div;
  logic        Tx_Active;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   fall_cyc = 0;
  int   last_grant_cyc = 0;
  int   tx_mode  = M_NORM;
  int   act_left = 0;
  int   act_len  = 0;
  bit   start_next = 1'b0;
  bit   saw_grant  = 1'b0;
  bit   busy_low_due = 1'b0;
  exp_t sb_q[$];
  exp_t pend_q[$];

  uart_tx_sched #(
    .NUM_REQ        (4),
    .DATA_W         (8),
    .DIV_W          (4),
    .TIMEOUT_W      (16),
    .TIMEOUT_CYCLES (WD_CYC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_data  (req_data),
    .req_div   (req_div),
    .grant     (grant),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .Tx_Drive  (Tx_Drive),
    .tx_data   (tx_data),
    .clk_div   (clk_div),
    .Tx_Active (Tx_Active)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] oh(int i);
    return 4'b0001 << i;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(int idx, logic [7:0] d, logic [3:0] v, bit is_err, int gap, int at_cyc);
    exp_t e;
    e.idx = idx; e.data = d; e.div = v; e.is_err = is_err;
    e.gap = gap; e.at_cyc = at_cyc; e.gcyc = 0;
    sb_q.push_back(e);
  endtask

  // One clock: sample 1 time unit after the edge, score, then advance the Tx model.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (busy_low_due) begin
      chk("busy_after_frame", 32'(busy), 0);
      busy_low_due = 1'b0;
    end
    if (grant != 4'b0000) begin
      if (sb_q.size() == 0) begin
        chk("grant_unexpected", 32'(grant), 0);
      end else begin
        e = sb_q.pop_front();
        chk("grant_vec", 32'(grant), 32'(oh(e.idx)));
        chk("drive_at_grant", 32'(Tx_Drive), 1);
        chk("tx_data_at_grant", 32'(tx_data), 32'(e.data));
        chk("clk_div_at_grant", 32'(clk_div), 32'(e.div));
        chk("busy_at_grant", 32'(busy), 1);
        if (e.gap != 0) chk("grant_gap", 32'(cyc - last_grant_cyc), 32'(e.gap));
        if (e.at_cyc != 0) chk("grant_cycle", 32'(cyc), 32'(e.at_cyc));
        e.gcyc = cyc;
        pend_q.push_back(e);
        last_grant_cyc = cyc;
        saw_grant = 1'b1;
      end
    end else begin
      chk("drive_without_grant", 32'(Tx_Drive), 0);
    end
    if (done != 4'b0000 || err != 4'b0000) begin
      if (pend_q.size() == 0) begin
        chk("done_unexpected", 32'(done), 0);
        chk("err_unexpected", 32'(err), 0);
      end else begin
        e = pend_q.pop_front();
        chk("done_vec", 32'(done), e.is_err ? 32'(0) : 32'(oh(e.idx)));
        chk("err_vec", 32'(err), e.is_err ? 32'(oh(e.idx)) : 32'(0));
        if (e.is_err) chk("err_cycle", 32'(cyc), 32'(e.gcyc + 1 + WD_CYC));
        else          chk("done_cycle", 32'(cyc), 32'(fall_cyc + 1));
        chk("tx_data_held", 32'(tx_data), 32'(e.data));
        chk("clk_div_held", 32'(clk_div), 32'(e.div));
        busy_low_due = 1'b1;
      end
    end
    // uart_tx stand-in: active from the cycle after Tx_Drive for 3+clk_div cycles.
    if (tx_mode == M_FORCE) begin
      Tx_Active = 1'b1;
    end else if (tx_mode == M_LOW) begin
      Tx_Active = 1'b0;
    end else begin
      if (start_next) begin
        Tx_Active  = 1'b1;
        act_left   = act_len;
        start_next = 1'b0;
      end else if (act_left > 0) begin
        act_left--;
        if (act_left == 0) begin
          Tx_Active = 1'b0;
          fall_cyc  = cyc;
        end
      end
      if (Tx_Drive) begin
        start_next = 1'b1;
        act_len    = 3 + int'(clk_div);
      end
    end
  endtask

  task automatic wait_grant(string tag, int budget);
    int n;
    n = 0;
    while (!saw_grant && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(saw_grant), 1);
  endtask

  task automatic drain(string tag, int budget);
    int n;
    n = 0;
    while ((sb_q.size() != 0 || pend_q.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    tick();
    chk(tag, 32'(sb_q.size() + pend_q.size()), 0);
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    int n;
    rst       = 1'b0;
    req       = 4'b0000;
    req_data  = 32'h0;
    req_div   = 16'h0;
    Tx_Active = 1'b0;

    // Reset state.
    tick();
    tick();
    chk("rst_grant", 32'(grant), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_drive", 32'(Tx_Drive), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    chk("rst_clk_div", 32'(clk_div), 0);
    rst = 1'b1;
    tick();

    // Single requester, payload changed while the frame is in flight.
    req_data = 32'h11_22_A5_33;
    req_div  = 16'h5_6_3_7;
    expect_frame(1, 8'hA5, 4'd3, 1'b0, 0, 0);
    saw_grant = 1'b0;
    req = 4'b0010;
    wait_grant("single_grant_seen", 5);
    req = 4'b0000;
    n = 0;
    while (!Tx_Active && n < 5) begin
      tick();
      n++;
    end
    tick();
    chk("single_busy_in_frame", 32'(busy), 1);
    req_data[15:8] = 8'h3C;
    req_div[7:4]   = 4'd9;
    drain("single_drain", 40);
    chk("single_tx_data_after", 32'(tx_data), 32'h000000A5);
    chk("single_clk_div_after", 32'(clk_div), 32'h3);

    // All four requesting from reset: rotation 0,1,2,3,0, gap = active time + 4.
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = 8'(8'h10 + i);
      req_div[i*4 +: 4]  = 4'(i + 1);
    end
    expect_frame(0, 8'h10, 4'd1, 1'b0, 0, 0);
    expect_frame(1, 8'h11, 4'd2, 1'b0, 3 + 1 + 4, 0);
    expect_frame(2, 8'h12, 4'd3, 1'b0, 3 + 2 + 4, 0);
    expect_frame(3, 8'h13, 4'd4, 1'b0, 3 + 3 + 4, 0);
    expect_frame(0, 8'h10, 4'd1, 1'b0, 3 + 4 + 4, 0);
    req = 4'b1111;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    req = 4'b0000;
    drain("rr_drain", 40);

    // Transmitter never goes active: watchdog abort on requester 2.
    tx_mode = M_LOW;
    req_data[23:16] = 8'hC3;
    req_div[11:8]   = 4'd5;
    expect_frame(2, 8'hC3, 4'd5, 1'b1, 0, 0);
    saw_grant = 1'b0;
    req = 4'b0100;
    wait_grant("timeout_grant_seen", 5);
    req = 4'b0000;
    drain("timeout_drain", 40);
    tx_mode = M_NORM;

    // Transmitter busy before the request: no grant until it drops.
    tx_mode = M_FORCE;
    tick();
    req = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("hold_no_grant", 32'(grant), 0);
      chk("hold_busy_low", 32'(busy), 0);
    end
    tx_mode   = M_NORM;
    Tx_Active = 1'b0;
    saw_grant = 1'b0;
    expect_frame(3, 8'h13, 4'd4, 1'b0, 0, cyc + 1);
    wait_grant("hold_grant_seen", 4);
    req = 4'b0000;
    drain("hold_drain", 40);

    // Reset in WAIT_END: frame dropped silently, pointer back to 0.
    req_data[7:0] = 8'h5A;
    req_div[3:0]  = 4'd2;
    expect_frame(0, 8'h5A, 4'd2, 1'b0, 0, 0);
    saw_grant = 1'b0;
    req = 4'b0001;
    wait_grant("abort_grant_seen", 5);
    req = 4'b0000;
    tick();
    tick();
    tick();
    chk("abort_busy_before", 32'(busy), 1);
    #2;
    rst = 1'b0;
    #1;
    chk("abort_grant", 32'(grant), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_err", 32'(err), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_drive", 32'(Tx_Drive), 0);
    chk("abort_tx_data", 32'(tx_data), 0);
    chk("abort_clk_div", 32'(clk_div), 0);
    pend_q.delete();
    act_left   = 0;
    start_next = 1'b0;
    Tx_Active  = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    expect_frame(0, 8'h5A, 4'd2, 1'b0, 0, 0);
    saw_grant = 1'b0;
    req = 4'b1111;
    wait_grant("post_reset_grant_seen", 5);
    req = 4'b0000;
    drain("post_reset_drain", 40);
    repeat (5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
